// File: rtl/gravador_tabuleiro.sv
// Board-write sequencer: bounds-checks a ship, reads its cells for overlap and
// writes it only when every cell is free; also clears one player's 10x10 board.
module gravador_tabuleiro (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       clear,
  input  logic [2:0] tipo,
  input  logic [3:0] X1,
  input  logic [3:0] Y1,
  input  logic       direcao,
  input  logic       jogador,
  output logic       busy,
  output logic       done,
  output logic       conflito,
  output logic [7:0] mem_addr,
  output logic       mem_rd,
  input  logic [2:0] mem_rdata,
  output logic       mem_wr,
  output logic [2:0] mem_wdata
);

  typedef enum logic [2:0] {
    IDLE,
    BOUNDS,
    READ,
    CHECK,
    WRITE,
    CLEAR,
    DONE
  } state_t;

  state_t     state;
  logic [2:0] tipo_q;
  logic [3:0] x_q;
  logic [3:0] y_q;
  logic       dir_q;
  logic       jog_q;
  logic [2:0] idx;
  logic [6:0] clr_cnt;
  logic       out_of_bounds;
  logic       last_cell;

  // Ship length is tipo+1, so the far end sits at origin+tipo (5-bit, no wrap).
  always_comb begin
    out_of_bounds = 1'b0;
    if (tipo_q > 3'd4)
      out_of_bounds = 1'b1;
    if (x_q > 4'd9 || y_q > 4'd9)
      out_of_bounds = 1'b1;
    if (!dir_q && (({1'b0, x_q} + {2'b00, tipo_q}) > 5'd9))
      out_of_bounds = 1'b1;
    if (dir_q && (({1'b0, y_q} + {2'b00, tipo_q}) > 5'd9))
      out_of_bounds = 1'b1;
    last_cell = (idx == tipo_q);
  end

  function automatic logic [7:0] cell_addr(input logic [2:0] n);
    logic [7:0] cx;
    logic [7:0] cy;
    cx = {4'b0000, x_q} + (dir_q ? 8'd0 : {5'b00000, n});
    cy = {4'b0000, y_q} + (dir_q ? {5'b00000, n} : 8'd0);
    return (jog_q ? 8'd100 : 8'd0) + cy * 8'd10 + cx;
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      conflito  <= 1'b0;
      mem_addr  <= '0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_wdata <= '0;
      tipo_q    <= '0;
      x_q       <= '0;
      y_q       <= '0;
      dir_q     <= 1'b0;
      jog_q     <= 1'b0;
      idx       <= '0;
      clr_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (clear) begin
            jog_q     <= jogador;
            clr_cnt   <= '0;
            conflito  <= 1'b0;
            busy      <= 1'b1;
            mem_wr    <= 1'b1;
            mem_wdata <= '0;
            mem_addr  <= jogador ? 8'd100 : 8'd0;
            state     <= CLEAR;
          end else if (start) begin
            tipo_q   <= tipo;
            x_q      <= X1;
            y_q      <= Y1;
            dir_q    <= direcao;
            jog_q    <= jogador;
            idx      <= '0;
            conflito <= 1'b0;
            busy     <= 1'b1;
            state    <= BOUNDS;
          end
        end
        BOUNDS: begin
          if (out_of_bounds) begin
            conflito <= 1'b1;
            done     <= 1'b1;
            state    <= DONE;
          end else begin
            mem_rd   <= 1'b1;
            mem_addr <= cell_addr(idx);
            state    <= READ;
          end
        end
        READ: begin
          mem_rd <= 1'b0;
          state  <= CHECK;
        end
        CHECK: begin
          if (mem_rdata != '0) begin
            conflito <= 1'b1;
            done     <= 1'b1;
            state    <= DONE;
          end else if (last_cell) begin
            idx       <= '0;
            mem_wr    <= 1'b1;
            mem_addr  <= cell_addr(3'd0);
            mem_wdata <= tipo_q + 3'd1;
            state     <= WRITE;
          end else begin
            idx      <= idx + 3'd1;
            mem_rd   <= 1'b1;
            mem_addr <= cell_addr(idx + 3'd1);
            state    <= READ;
          end
        end
        WRITE: begin
          if (last_cell) begin
            mem_wr   <= 1'b0;
            done     <= 1'b1;
            conflito <= 1'b0;
            state    <= DONE;
          end else begin
            idx      <= idx + 3'd1;
            mem_addr <= cell_addr(idx + 3'd1);
          end
        end
        CLEAR: begin
          if (clr_cnt == 7'd99) begin
            mem_wr <= 1'b0;
            done   <= 1'b1;
            state  <= DONE;
          end else begin
            clr_cnt  <= clr_cnt + 7'd1;
            mem_addr <= mem_addr + 8'd1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
